abr_prim_onehot_wr_dec: RTL and testbench

ABR_PRIM_ONEHOT_WR_DEC -- requirements
Module: abr_prim_onehot_wr_dec

---
 rtl/abr_prim_pkg.sv | 21 ++
 rtl/abr_prim_onehot_wr_dec.sv | 113 +++++++++++
 tb/tb_abr_prim_onehot_wr_dec.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/abr_prim_pkg.sv
// Shared types for the abr_prim one-hot write path.
// State codes are sparse with pairwise Hamming distance >= 3, so a single or
// double bit flip in the state register never lands on another legal state.
package abr_prim_pkg;

  localparam int unsigned StateWidth = 5;

  // IDLE^ACTIVE = 4 bits, IDLE^ERROR = 3 bits, ACTIVE^ERROR = 3 bits.
  typedef enum logic [StateWidth-1:0] {
    ST_IDLE   = 5'b01100,
    ST_ACTIVE = 5'b10010,
    ST_ERROR  = 5'b11001
  } wr_dec_state_e;

  // Any code that is neither IDLE nor ACTIVE is treated as an error state,
  // including the illegal encodings.
  function automatic logic state_is_error(wr_dec_state_e st);
    return (st != ST_IDLE) && (st != ST_ACTIVE);
  endfunction

endpackage

// File: rtl/abr_prim_onehot_wr_dec.sv
// Purpose: registered one-hot write-enable decoder with a sticky fatal-error FSM.
// Latency: 1 cycle from request acceptance to oh_o/addr_o/en_o.
// Backpressure: single-entry stage; req_ready_o drops while a beat is stalled by oh_ready_i.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake, req_addr_i is the target index
//   oh_o, addr_o, en_o        registered write beat; completes when en_o && oh_ready_i
//   chk_err_i                 error from the downstream one-hot checker
//   fatal_err_o               sticky error, cleared only by rst_i
//   wr_cnt_o                  saturating count of completed beats
module abr_prim_onehot_wr_dec
  import abr_prim_pkg::*;
#(
  parameter int AddrWidth   = 5,
  parameter int OneHotWidth = 2 ** AddrWidth,
  parameter int CntWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  output logic [OneHotWidth-1:0] oh_o,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   en_o,
  input  logic                   oh_ready_i,
  input  logic                   chk_err_i,
  output logic                   fatal_err_o,
  output logic [CntWidth-1:0]    wr_cnt_o
);

  // One extra bit so OneHotWidth == 2**AddrWidth is representable.
  localparam logic [AddrWidth:0] OhLimit = (AddrWidth + 1)'(OneHotWidth);
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  wr_dec_state_e          state_q, state_d;
  logic [OneHotWidth-1:0] oh_q, oh_dec;
  logic [AddrWidth-1:0]   addr_q;
  logic                   en_q;
  logic [CntWidth-1:0]    cnt_q;

  logic in_range, accept, load, beat_done;

  assign in_range    = {1'b0, req_addr_i} < OhLimit;
  assign req_ready_o = !rst_i && (state_q == ST_ACTIVE) && (!en_q || oh_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign load        = accept && in_range;
  assign beat_done   = en_q && oh_ready_i;

  always_comb begin
    oh_dec = '0;
    for (int i = 0; i < OneHotWidth; i++) begin
      oh_dec[i] = (req_addr_i == AddrWidth'(i));
    end
  end

  // Next-state logic. chk_err_i is honoured in IDLE as well as ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = chk_err_i ? ST_ERROR : ST_ACTIVE;
      ST_ACTIVE: if (chk_err_i || (accept && !in_range)) state_d = ST_ERROR;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      oh_q    <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Leaving ACTIVE squashes the pending beat; addr_q keeps its last value.
      if (state_d != ST_ACTIVE) begin
        oh_q <= '0;
        en_q <= 1'b0;
      end else if (load) begin
        oh_q   <= oh_dec;
        addr_q <= req_addr_i;
        en_q   <= 1'b1;
      end else if (beat_done) begin
        oh_q <= '0;
        en_q <= 1'b0;
      end
      // A beat that completes in the same cycle as an error is not counted.
      if (beat_done && (state_d == ST_ACTIVE) && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  assign oh_o        = oh_q;
  assign addr_o      = addr_q;
  assign en_o        = en_q;
  assign wr_cnt_o    = cnt_q;
  assign fatal_err_o = state_is_error(state_q);

`ifndef SYNTHESIS
  a_oh_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(oh_o));
  a_en_matches : assert property (@(posedge clk_i) disable iff (rst_i) en_o == (|oh_o));
  a_stall_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (en_o && !oh_ready_i) |=> (fatal_err_o ||
      ($stable(oh_o) && $stable(addr_o) && $stable(en_o))));
  a_fatal_sticky : assert property (@(posedge clk_i) disable iff (rst_i)
    ($past(fatal_err_o) && !$past(rst_i)) |-> fatal_err_o);
`endif

endmodule

// File: tb/tb_abr_prim_onehot_wr_dec.sv
// Bench for abr_prim_onehot_wr_dec: two instances (default parameters and a
// narrow OneHotWidth=20 / CntWidth=2 variant), each driven from a table of
// per-cycle vectors with hand-computed expected outputs.
module tb_abr_prim_onehot_wr_dec;

  typedef struct {
    logic        rst, vld, rdy, err;
    logic [4:0]  addr;
    logic        e_rdy;   // req_ready_o before the edge
    logic        e_en;    // registered outputs after the edge
    logic [31:0] e_oh;
    logic [4:0]  e_addr;
    logic [15:0] e_cnt;
    logic        e_fatal;
  } vec_t;

  typedef struct {
    int          idx;
    logic        en;
    logic [31:0] oh;
    logic [4:0]  addr;
    logic [15:0] cnt;
    logic        fatal;
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default parameters
  logic        rst0, vld0, ordy0, err0, rdy0_o, en0_o, fat0_o;
  logic [4:0]  addr0, addr0_o;
  logic [31:0] oh0_o;
  logic [15:0] cnt0_o;

  // DUT 1: OneHotWidth = 20, CntWidth = 2
  logic        rst1, vld1, ordy1, err1, rdy1_o, en1_o, fat1_o;
  logic [4:0]  addr1, addr1_o;
  logic [19:0] oh1_o;
  logic [1:0]  cnt1_o;

  abr_prim_onehot_wr_dec u_dut0 (
    .clk_i(clk), .rst_i(rst0), .req_valid_i(vld0), .req_ready_o(rdy0_o),
    .req_addr_i(addr0), .oh_o(oh0_o), .addr_o(addr0_o), .en_o(en0_o),
    .oh_ready_i(ordy0), .chk_err_i(err0), .fatal_err_o(fat0_o), .wr_cnt_o(cnt0_o)
  );

  abr_prim_onehot_wr_dec #(.AddrWidth(5), .OneHotWidth(20), .CntWidth(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .req_valid_i(vld1), .req_ready_o(rdy1_o),
    .req_addr_i(addr1), .oh_o(oh1_o), .addr_o(addr1_o), .en_o(en1_o),
    .oh_ready_i(ordy1), .chk_err_i(err1), .fatal_err_o(fat1_o), .wr_cnt_o(cnt1_o)
  );

  int sel;
  logic        o_rdy, o_en, o_fatal;
  logic [31:0] o_oh;
  logic [4:0]  o_addr;
  logic [15:0] o_cnt;

  always_comb begin
    o_rdy   = (sel == 0) ? rdy0_o  : rdy1_o;
    o_en    = (sel == 0) ? en0_o   : en1_o;
    o_fatal = (sel == 0) ? fat0_o  : fat1_o;
    o_oh    = (sel == 0) ? oh0_o   : {12'b0, oh1_o};
    o_addr  = (sel == 0) ? addr0_o : addr1_o;
    o_cnt   = (sel == 0) ? cnt0_o  : {14'b0, cnt1_o};
  end

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl0[$];
  vec_t tbl1[$];

  function automatic vec_t mk(logic rst, logic vld, logic [4:0] addr, logic rdy, logic err,
                              logic e_rdy, logic e_en, logic [31:0] e_oh,
                              logic [4:0] e_addr, logic [15:0] e_cnt, logic e_fatal);
    vec_t v;
    v.rst = rst; v.vld = vld; v.addr = addr; v.rdy = rdy; v.err = err;
    v.e_rdy = e_rdy; v.e_en = e_en; v.e_oh = e_oh; v.e_addr = e_addr;
    v.e_cnt = e_cnt; v.e_fatal = e_fatal;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d row %0d: got %h want %h", name, sel, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [4:0] addr,
                       input logic rdy, input logic err);
    if (sel == 0) begin
      rst0 = rst; vld0 = vld; addr0 = addr; ordy0 = rdy; err0 = err;
    end else begin
      rst1 = rst; vld1 = vld; addr1 = addr; ordy1 = rdy; err1 = err;
    end
  endtask

  // Hold reset for two edges and check the reset values while rst is still high.
  task automatic reset_dut(input int s);
    sel = s;
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", -1, {31'b0, o_rdy}, 32'd0);
    chk("rst_en",    -1, {31'b0, o_en}, 32'd0);
    chk("rst_oh",    -1, o_oh, 32'd0);
    chk("rst_addr",  -1, {27'b0, o_addr}, 32'd0);
    chk("rst_cnt",   -1, {16'b0, o_cnt}, 32'd0);
    chk("rst_fatal", -1, {31'b0, o_fatal}, 32'd0);
  endtask

  task automatic run_row(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    drive(v.rst, v.vld, v.addr, v.rdy, v.err);
    #1;
    chk("req_ready", idx, {31'b0, o_rdy}, {31'b0, v.e_rdy});
    e.idx = idx; e.en = v.e_en; e.oh = v.e_oh; e.addr = v.e_addr;
    e.cnt = v.e_cnt; e.fatal = v.e_fatal;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty dut%0d row %0d: got 0 entries want 1", sel, idx);
    end else begin
      got = sb.pop_front();
      chk("en",    got.idx, {31'b0, o_en}, {31'b0, got.en});
      chk("oh",    got.idx, o_oh, got.oh);
      chk("addr",  got.idx, {27'b0, o_addr}, {27'b0, got.addr});
      chk("cnt",   got.idx, {16'b0, o_cnt}, {16'b0, got.cnt});
      chk("fatal", got.idx, {31'b0, o_fatal}, {31'b0, got.fatal});
    end
  endtask

  initial begin
    sel = 0;
    rst0 = 1'b1; vld0 = 1'b0; addr0 = '0; ordy0 = 1'b0; err0 = 1'b0;
    rst1 = 1'b1; vld1 = 1'b0; addr1 = '0; ordy1 = 1'b0; err1 = 1'b0;

    //               rst  vld addr  rdy  err | rdy  en  oh            addr cnt fatal
    // first cycle after reset is IDLE: no acceptance
    tbl0.push_back(mk(0, 1, 5'd5,  1, 0,   0, 0, 32'h0,         5'd0,  0, 0));
    // addr 5, completes the following cycle
    tbl0.push_back(mk(0, 1, 5'd5,  1, 0,   1, 1, 32'h20,        5'd5,  0, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  1, 0,   1, 0, 32'h0,         5'd5,  1, 0));
    // back-to-back 0, 31, 7 with no bubble
    tbl0.push_back(mk(0, 1, 5'd0,  1, 0,   1, 1, 32'h1,         5'd0,  1, 0));
    tbl0.push_back(mk(0, 1, 5'd31, 1, 0,   1, 1, 32'h8000_0000, 5'd31, 2, 0));
    tbl0.push_back(mk(0, 1, 5'd7,  1, 0,   1, 1, 32'h80,        5'd7,  3, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  1, 0,   1, 0, 32'h0,         5'd7,  4, 0));
    // addr 3 then 4 stalled cycles; a different valid addr must not be taken
    tbl0.push_back(mk(0, 1, 5'd3,  0, 0,   1, 1, 32'h8,         5'd3,  4, 0));
    for (int i = 0; i < 4; i++)
      tbl0.push_back(mk(0, 1, 5'd9, 0, 0,  0, 1, 32'h8,         5'd3,  4, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  1, 0,   1, 0, 32'h0,         5'd3,  5, 0));
    // stalled beat squashed by a 1-cycle chk_err pulse; fatal sticks
    tbl0.push_back(mk(0, 1, 5'd12, 0, 0,   1, 1, 32'h1000,      5'd12, 5, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  0, 1,   0, 0, 32'h0,         5'd12, 5, 1));
    tbl0.push_back(mk(0, 1, 5'd1,  1, 0,   0, 0, 32'h0,         5'd12, 5, 1));
    tbl0.push_back(mk(0, 1, 5'd1,  1, 0,   0, 0, 32'h0,         5'd12, 5, 1));
    // reset clears error; then reset mid-stall discards the beat
    tbl0.push_back(mk(1, 0, 5'd0,  0, 0,   0, 0, 32'h0,         5'd0,  0, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  0, 0,   0, 0, 32'h0,         5'd0,  0, 0));
    tbl0.push_back(mk(0, 1, 5'd2,  0, 0,   1, 1, 32'h4,         5'd2,  0, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  0, 0,   0, 1, 32'h4,         5'd2,  0, 0));
    tbl0.push_back(mk(1, 0, 5'd0,  1, 0,   0, 0, 32'h0,         5'd0,  0, 0));
    tbl0.push_back(mk(0, 0, 5'd0,  0, 0,   0, 0, 32'h0,         5'd0,  0, 0));
    // chk_err in the same cycle as an acceptance: nothing is loaded
    tbl0.push_back(mk(0, 1, 5'd4,  1, 1,   1, 0, 32'h0,         5'd0,  0, 1));

    // narrow instance: highest legal index, counter saturation, out-of-range addr
    tbl1.push_back(mk(0, 0, 5'd0,  0, 0,   0, 0, 32'h0,         5'd0,  0, 0));
    tbl1.push_back(mk(0, 1, 5'd19, 1, 0,   1, 1, 32'h8_0000,    5'd19, 0, 0));
    tbl1.push_back(mk(0, 1, 5'd0,  1, 0,   1, 1, 32'h1,         5'd0,  1, 0));
    tbl1.push_back(mk(0, 1, 5'd1,  1, 0,   1, 1, 32'h2,         5'd1,  2, 0));
    tbl1.push_back(mk(0, 1, 5'd2,  1, 0,   1, 1, 32'h4,         5'd2,  3, 0));
    tbl1.push_back(mk(0, 1, 5'd3,  1, 0,   1, 1, 32'h8,         5'd3,  3, 0));
    tbl1.push_back(mk(0, 0, 5'd0,  1, 0,   1, 0, 32'h0,         5'd3,  3, 0));
    tbl1.push_back(mk(0, 1, 5'd25, 1, 0,   1, 0, 32'h0,         5'd3,  3, 1));
    tbl1.push_back(mk(0, 1, 5'd0,  1, 0,   0, 0, 32'h0,         5'd3,  3, 1));
    tbl1.push_back(mk(0, 0, 5'd0,  1, 0,   0, 0, 32'h0,         5'd3,  3, 1));

    reset_dut(0);
    for (int i = 0; i < tbl0.size(); i++) run_row(tbl0[i], i);

    reset_dut(1);
    for (int i = 0; i < tbl1.size(); i++) run_row(tbl1[i], i);

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
